fetch_queue: RTL and testbench



---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_queue.sv | 82 ++++++++
 tb/tb_fetch_queue.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-queue entry type.
// The entry type pairs an instruction with the PC it was fetched from.
package cpu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned INS_W = 32;

    localparam logic [XLEN-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [INS_W-1:0] ins;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a combinational head read and a single-cycle flush.
// Callers must not push when full or pop when empty.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Storage needs no reset; only the pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, one-cycle imem request port and
// a small queue delivering {pc, instruction} pairs to the decoder.
module fetch_queue #(
    parameter int unsigned     XLEN     = cpu_pkg::XLEN,
    parameter int unsigned     INS_W    = cpu_pkg::INS_W,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     ADDR_W   = 8,
    parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic                       clk,
    input  logic                       rstd,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [INS_W-1:0]           imem_rdata,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INS_W-1:0]           out_ins,
    output logic [XLEN-1:0]            out_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    logic [XLEN-1:0]       fetch_pc_q;
    logic [XLEN-1:0]       fetch_pc_d;
    logic [XLEN-1:0]       inflight_pc_q;
    logic [XLEN-1:0]       inflight_pc_d;
    logic                  inflight_q;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [31:0]           occupancy;
    logic [XLEN+INS_W-1:0] head;

    // A request reserves a queue slot, so in-flight words count toward occupancy.
    always_comb begin
        occupancy     = 32'(count) + 32'(inflight_q);
        issue         = !rstd && !redirect_valid && (occupancy < DEPTH);
        push          = inflight_q && !redirect_valid;
        pop           = out_valid && out_ready && !redirect_valid;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + XLEN'(4);
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rstd) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= issue;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + INS_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rstd),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({inflight_pc_q, imem_rdata}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign imem_req          = issue;
    assign imem_addr         = fetch_pc_q[ADDR_W-1:0];
    assign out_valid         = (count != '0);
    assign {out_pc, out_ins} = head;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a queue-based model checked every cycle,
// plus hand-computed expectations at the key cycles of each scenario.
module tb_fetch_queue;
    import cpu_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 8;

    logic        clk = 1'b0;
    logic        rstd = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic [2:0]  count;

    always #5 clk = ~clk;

    fetch_queue #(
        .XLEN     (32),
        .INS_W    (32),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rstd           (rstd),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ins        (out_ins),
        .out_pc         (out_pc),
        .count          (count)
    );

    // ROM: word i holds i, answered one cycle after the address is presented.
    always @(posedge clk) imem_rdata <= 32'(imem_addr >> 2);

    int           checks = 0;
    int           errors = 0;
    bit           started = 1'b0;
    fetch_entry_t model_q[$];
    logic [31:0]  pend_q[$];
    logic [31:0]  m_pc = 32'h0;

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return 32'(pc[7:0] >> 2);
    endfunction

    // Advances the model by one clock using the inputs of the cycle just ending.
    task automatic model_update();
        bit           req;
        fetch_entry_t e;
        req = !rstd && !redirect_valid && (model_q.size() + pend_q.size() < DEPTH);
        if (rstd || redirect_valid) begin
            model_q.delete();
            pend_q.delete();
            m_pc = rstd ? 32'h0 : (redirect_pc & 32'hFFFF_FFFC);
        end else begin
            if (out_ready && model_q.size() != 0) void'(model_q.pop_front());
            if (pend_q.size() != 0) begin
                e.pc  = pend_q.pop_front();
                e.ins = rom_word(e.pc);
                model_q.push_back(e);
            end
            if (req) begin
                pend_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare();
        bit exp_req;
        exp_req = !rstd && !redirect_valid && (model_q.size() + pend_q.size() < DEPTH);
        pin("imem_req", 32'(imem_req), 32'(exp_req));
        pin("imem_addr", 32'(imem_addr), 32'(m_pc[7:0]));
        pin("count", 32'(count), 32'(model_q.size()));
        pin("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            pin("out_pc", out_pc, model_q[0].pc);
            pin("out_ins", out_ins, model_q[0].ins);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (started) compare();
    end

    task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        model_update();
        #1;
        rstd           = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    initial begin
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        started = 1'b1;

        // Reset release with the decoder always ready.
        step(1'b0, 1'b0, 32'h0, 1'b1); look();
        pin("c0_req", 32'(imem_req), 32'd1);
        pin("c0_addr", 32'(imem_addr), 32'h0);
        pin("c0_valid", 32'(out_valid), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1); look();
        pin("c1_valid", 32'(out_valid), 32'd0);
        pin("c1_addr", 32'(imem_addr), 32'h4);
        step(1'b0, 1'b0, 32'h0, 1'b1); look();
        pin("c2_valid", 32'(out_valid), 32'd1);
        pin("c2_pc", out_pc, 32'h0);
        pin("c2_ins", out_ins, 32'h0);
        pin("c2_count", 32'(count), 32'd1);
        step(1'b0, 1'b0, 32'h0, 1'b1); look();
        pin("c3_pc", out_pc, 32'h4);
        pin("c3_ins", out_ins, 32'h1);
        pin("c3_count", 32'(count), 32'd1);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Decoder stalled: queue fills, then drains in order.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0);
        look();
        pin("fill_count", 32'(count), 32'd4);
        pin("fill_req", 32'(imem_req), 32'd0);
        pin("fill_head", out_pc, 32'h0);
        pin("fill_addr", 32'(imem_addr), 32'h10);
        step(1'b0, 1'b0, 32'h0, 1'b1); look();
        pin("drain0_count", 32'(count), 32'd4);
        pin("drain0_req", 32'(imem_req), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1); look();
        pin("drain1_count", 32'(count), 32'd3);
        pin("drain1_req", 32'(imem_req), 32'd1);
        pin("drain1_pc", out_pc, 32'h4);
        step(1'b0, 1'b0, 32'h0, 1'b1); look();
        pin("drain2_count", 32'(count), 32'd2);
        pin("drain2_pc", out_pc, 32'h8);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Push and pop together at count = DEPTH-1.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1); look();
        pin("pp3_count_a", 32'(count), 32'd3);
        pin("pp3_req", 32'(imem_req), 32'd0);
        pin("pp3_pc_a", out_pc, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1); look();
        pin("pp3_count_b", 32'(count), 32'd3);
        pin("pp3_pc_b", out_pc, 32'h4);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect with three entries queued and one response in flight.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h41, 1'b1); look();
        pin("rd_count", 32'(count), 32'd3);
        pin("rd_valid", 32'(out_valid), 32'd1);
        pin("rd_pc", out_pc, 32'h0);
        pin("rd_req", 32'(imem_req), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1); look();
        pin("rd1_count", 32'(count), 32'd0);
        pin("rd1_valid", 32'(out_valid), 32'd0);
        pin("rd1_req", 32'(imem_req), 32'd1);
        pin("rd1_addr", 32'(imem_addr), 32'h40);
        step(1'b0, 1'b0, 32'h0, 1'b1); look();
        pin("rd2_valid", 32'(out_valid), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1); look();
        pin("rd3_valid", 32'(out_valid), 32'd1);
        pin("rd3_pc", out_pc, 32'h40);
        pin("rd3_ins", out_ins, 32'h10);

        // PC wrap at the top of the address space; low bits of the target ignored.
        step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1); look();
        pin("wrap1_addr", 32'(imem_addr), 32'hFC);
        step(1'b0, 1'b0, 32'h0, 1'b1); look();
        pin("wrap2_addr", 32'(imem_addr), 32'h00);
        step(1'b0, 1'b0, 32'h0, 1'b1); look();
        pin("wrap3_pc", out_pc, 32'hFFFF_FFFC);
        pin("wrap3_ins", out_ins, 32'h3F);
        step(1'b0, 1'b0, 32'h0, 1'b1); look();
        pin("wrap4_pc", out_pc, 32'h0);
        pin("wrap4_ins", out_ins, 32'h0);

        // Reset (together with a redirect) while occupancy is at DEPTH.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h80, 1'b0); look();
        pin("rst_req", 32'(imem_req), 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b0); look();
        pin("rst1_count", 32'(count), 32'd0);
        pin("rst1_valid", 32'(out_valid), 32'd0);
        pin("rst1_req", 32'(imem_req), 32'd0);
        pin("rst1_addr", 32'(imem_addr), 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1); look();
        pin("rst2_req", 32'(imem_req), 32'd1);
        pin("rst2_addr", 32'(imem_addr), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
